cs_decoder_static_seq: RTL and testbench

CS_DECODER_STATIC_SEQ -- requirements
Module: cs_decoder_static_seq

---
 rtl/cs_pkg.sv | 91 +++++++++
 rtl/cs_decoder_static_seq_buf.sv | 38 +++
 rtl/cs_decoder_static_seq.sv | 147 ++++++++++++++
 tb/tb_cs_decoder_static_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the static cyclic-lifted code: FSM state, lifting and rotation helpers, default code.
// Combinational helpers only; no latency.
// No flow control here; users apply these to constant code masks and data words.
package cs_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SOLVE   = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // Default code geometry: 5 coded symbols, 3 data symbols, 11-bit lifted words
  localparam int CS_K = 5;
  localparam int CS_M = 3;
  localparam int CS_L = 11;

  // Helpers operate on a fixed wide word; the live width is passed as len
  localparam int CS_LMAX = 32;
  localparam int CS_IW   = $clog2(CS_LMAX);

  typedef logic [CS_LMAX-1:0] lword_t;
  typedef logic [CS_K-1:0][CS_M-1:0][CS_L-1:0] coeff_t;

  // Rotate the low len bits of x left by s
  function automatic lword_t rotl(input lword_t x, input int s, input int len);
    lword_t r;
    r = '0;
    for (int i = 0; i < CS_LMAX; i++) begin
      if (i < len) r[CS_IW'((i + s) % len)] = x[i];
    end
    return r;
  endfunction

  // Rotate the low len bits of x right by s
  function automatic lword_t rotr(input lword_t x, input int s, input int len);
    return rotl(x, (len - (s % len)) % len, len);
  endfunction

  // Append the parity of the low len-1 bits at bit len-1, making an even-weight word
  function automatic lword_t lift(input lword_t s, input int len);
    lword_t r;
    logic   p;
    r = '0;
    p = 1'b0;
    for (int i = 0; i < CS_LMAX; i++) begin
      if (i < len - 1) begin
        r[i] = s[i];
        p    = p ^ s[i];
      end
    end
    r[CS_IW'(len - 1)] = p;
    return r;
  endfunction

  // Multiply x by a coefficient mask in the cyclic ring (XOR of rotations)
  function automatic lword_t cmul(input lword_t x, input lword_t mask, input int len);
    lword_t acc;
    acc = '0;
    for (int k = 0; k < CS_LMAX; k++) begin
      if (k < len && mask[k]) acc = acc ^ rotl(x, k, len);
    end
    return acc;
  endfunction

  // Rotation amount encoded by a one-hot coefficient mask
  function automatic int mask_shift(input lword_t mask);
    int sh;
    sh = 0;
    for (int i = CS_LMAX - 1; i >= 0; i--) begin
      if (mask[i]) sh = i;
    end
    return sh;
  endfunction

  // Systematic rows 0..2, then row3 = d0 ^ rot1(d1), row4 = rot3(d0) ^ d2
  function automatic coeff_t default_coeff();
    coeff_t c;
    c       = '0;
    c[0][0] = 11'h001;
    c[1][1] = 11'h001;
    c[2][2] = 11'h001;
    c[3][0] = 11'h001;
    c[3][1] = 11'h002;
    c[4][0] = 11'h008;
    c[4][2] = 11'h001;
    return c;
  endfunction

  localparam coeff_t DEFAULT_COEFF = default_coeff();

endpackage

// File: rtl/cs_decoder_static_seq_buf.sv
// Coded-symbol store: K slots of W bits with a present bitmap, one write port, all slots readable in parallel.
// Write visible one cycle after wr_i; reads are combinational from the registers.
// No backpressure; the owner gates wr_i and pulses clr_i between generations.
module cs_sym_buf
  import cs_pkg::*;
#(
  parameter int K = 5,
  parameter int W = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [$clog2(K)-1:0]       wr_idx_i,
  input  logic [W-1:0]               wr_data_i,
  output logic [K-1:0][W-1:0]        slots_o,
  output logic [K-1:0]               present_o
);

  // Present bitmap: set on write, cleared by reset or end of generation
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      present_o <= '0;
    end else if (wr_i) begin
      present_o[wr_idx_i] <= 1'b1;
    end
  end

  // Slot data: a repeated index simply overwrites the earlier symbol
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_o <= '0;
    end else if (wr_i) begin
      slots_o[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cs_decoder_static_seq.sv
// Sequential decoder for the static lifted code: collect a generation, peel one column per cycle, present the result.
// SOLVE takes at most M+1 cycles after the last symbol; the result then sits in OUTPUT.
// sym_ready_o is low outside COLLECT; the result holds until dec_valid_o && dec_ready_i.
module cs_decoder_static_seq
  import cs_pkg::*;
#(
  parameter int K = 5,
  parameter int M = 3,
  parameter int L = 11,
  parameter logic [K-1:0][M-1:0][L-1:0] COEFF = DEFAULT_COEFF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sym_valid_i,
  output logic                      sym_ready_o,
  input  logic [$clog2(K)-1:0]      sym_idx_i,
  input  logic [L-2:0]              sym_data_i,
  input  logic                      sym_last_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [M-1:0][L-2:0]       dec_data_o,
  output logic                      dec_ok_o,
  output logic [M-1:0]              dec_lost_o,
  output logic                      bad_idx_o
);

  state_t                state;
  logic [M-1:0]          rec;
  logic [M-1:0][L-2:0]   rec_dat;
  logic [K-1:0]          present;
  logic [K-1:0][L-2:0]   slots;
  logic                  xfer;
  logic                  idx_ok;
  logic                  buf_wr;
  logic                  buf_clr;

  logic [M-1:0]          known_w;
  logic [M-1:0][L-2:0]   val;
  logic [M-1:0][L-2:0]   out_dat;
  logic                  found;
  logic [M-1:0]          pick_oh;
  logic [L-2:0]          pick_val;
  logic                  row_ok;
  lword_t                acc;

  assign sym_ready_o = (state == ST_COLLECT);
  assign dec_valid_o = (state == ST_OUTPUT);
  assign xfer        = sym_valid_i && sym_ready_o;
  assign idx_ok      = (int'(sym_idx_i) < K);
  assign buf_wr      = xfer && idx_ok;
  assign buf_clr     = dec_valid_o && dec_ready_i;

  cs_sym_buf #(
    .K (K),
    .W (L - 1)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (buf_clr),
    .wr_i      (buf_wr),
    .wr_idx_i  (sym_idx_i),
    .wr_data_i (sym_data_i),
    .slots_o   (slots),
    .present_o (present)
  );

  // Current knowledge per data column: received directly or recovered earlier
  always_comb begin
    known_w = '0;
    val     = '0;
    out_dat = '0;
    for (int c = 0; c < M; c++) begin
      known_w[c] = present[c] || rec[c];
      val[c]     = present[c] ? slots[c] : rec_dat[c];
      out_dat[c] = known_w[c] ? val[c] : '0;
    end
  end

  // Find the lowest unknown column with a present parity row whose other terms are all known, and solve it
  always_comb begin
    found    = 1'b0;
    pick_oh  = '0;
    pick_val = '0;
    row_ok   = 1'b0;
    acc      = '0;
    for (int c = 0; c < M; c++) begin
      for (int r = M; r < K; r++) begin
        row_ok = present[r] && (COEFF[r][c] != '0) && !known_w[c];
        for (int j = 0; j < M; j++) begin
          if (j != c && COEFF[r][j] != '0 && !known_w[j]) row_ok = 1'b0;
        end
        if (row_ok && !found) begin
          found      = 1'b1;
          pick_oh[c] = 1'b1;
          acc        = lift(lword_t'(slots[r]), L);
          for (int j = 0; j < M; j++) begin
            if (j != c && COEFF[r][j] != '0) begin
              acc = acc ^ cmul(lift(lword_t'(val[j]), L), lword_t'(COEFF[r][j]), L);
            end
          end
          pick_val = (L-1)'(rotr(acc, mask_shift(lword_t'(COEFF[r][c])), L));
        end
      end
    end
  end

  // Generation FSM with registered result outputs and the sticky bad-index flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_COLLECT;
      rec        <= '0;
      rec_dat    <= '0;
      dec_data_o <= '0;
      dec_ok_o   <= 1'b0;
      dec_lost_o <= '0;
      bad_idx_o  <= 1'b0;
    end else begin
      if (xfer && !idx_ok) bad_idx_o <= 1'b1;
      case (state)
        ST_COLLECT: begin
          if (xfer && sym_last_i) state <= ST_SOLVE;
        end
        ST_SOLVE: begin
          if ((&known_w) || !found) begin
            state      <= ST_OUTPUT;
            dec_data_o <= out_dat;
            dec_ok_o   <= &known_w;
            dec_lost_o <= ~known_w;
          end else begin
            rec <= rec | pick_oh;
            for (int c = 0; c < M; c++) begin
              if (pick_oh[c]) rec_dat[c] <= pick_val;
            end
          end
        end
        ST_OUTPUT: begin
          if (dec_ready_i) begin
            state <= ST_COLLECT;
            rec   <= '0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_decoder_static_seq.sv
// Randomised scoreboard bench for cs_decoder_static_seq with an encode-and-peel reference model.
// Driver pushes expected results; a negedge monitor pops on each output handshake.
// dec_ready_i is randomly throttled, with a forced stall window.
module tb_cs_decoder_static_seq;
  localparam int K  = 5;
  localparam int M  = 3;
  localparam int L  = 11;
  localparam int IW = $clog2(K);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                sym_valid_i;
  logic                sym_ready_o;
  logic [IW-1:0]       sym_idx_i;
  logic [L-2:0]        sym_data_i;
  logic                sym_last_i;
  logic                dec_valid_o;
  logic                dec_ready_i;
  logic [M-1:0][L-2:0] dec_data_o;
  logic                dec_ok_o;
  logic [M-1:0]        dec_lost_o;
  logic                bad_idx_o;

  always #5 clk_i = ~clk_i;

  cs_decoder_static_seq #(.K(K), .M(M), .L(L)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .sym_idx_i   (sym_idx_i),
    .sym_data_i  (sym_data_i),
    .sym_last_i  (sym_last_i),
    .dec_valid_o (dec_valid_o),
    .dec_ready_i (dec_ready_i),
    .dec_data_o  (dec_data_o),
    .dec_ok_o    (dec_ok_o),
    .dec_lost_o  (dec_lost_o),
    .bad_idx_o   (bad_idx_o)
  );

  typedef struct { int idx; logic [L-2:0] data; } beat_t;
  typedef struct { logic [M-1:0][L-2:0] data; logic ok; logic [M-1:0] lost; logic bad; } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic exp_bad = 1'b0;
  bit   stall_force = 1'b0;

  // Rotation amount of each code entry, -1 where the entry is zero
  int sh [K][M] = '{'{0, -1, -1}, '{-1, 0, -1}, '{-1, -1, 0}, '{0, 1, -1}, '{3, -1, 0}};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] lift_m(input logic [L-2:0] s);
    return {^s, s};
  endfunction

  function automatic logic [L-1:0] rotl_m(input logic [L-1:0] x, input int s);
    logic [2*L-1:0] w;
    w = {x, x} << s;
    return w[2*L-1 -: L];
  endfunction

  function automatic logic [L-2:0] encode(input logic [M-1:0][L-2:0] d, input int r);
    logic [L-1:0] acc;
    acc = '0;
    for (int c = 0; c < M; c++)
      if (sh[r][c] >= 0) acc = acc ^ rotl_m(lift_m(d[c]), sh[r][c]);
    return acc[L-2:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!sym_ready_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!sym_ready_o) begin
      n_total++; n_bad++;
      $display("FAIL wait_sym_ready timed out t=%0t", $time);
    end
  endtask

  // Build one generation from data d and the set of coded rows to deliver, then drive it
  task automatic send_gen(input logic [M-1:0][L-2:0] d, input logic [K-1:0] pick,
                          input int nbad, input int ndup, input bit expect_out);
    beat_t beats[$];
    beat_t tmp;
    exp_t  e;
    logic [M-1:0] known;
    bit    changed;
    int    j, cnt, u, n;
    for (int r = 0; r < K; r++)
      if (pick[r]) begin tmp.idx = r; tmp.data = encode(d, r); beats.push_back(tmp); end
    for (int i = beats.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = beats[i]; beats[i] = beats[j]; beats[j] = tmp;
    end
    if (pick != '0)
      for (int i = 0; i < ndup; i++) begin
        do tmp.idx = $urandom_range(0, K - 1); while (!pick[tmp.idx]);
        tmp.data = (L-1)'($urandom);
        beats.push_front(tmp);
      end
    for (int i = 0; i < nbad; i++) begin
      tmp.idx = $urandom_range(K, (1 << IW) - 1); tmp.data = (L-1)'($urandom);
      beats.insert($urandom_range(0, beats.size()), tmp);
    end
    if (beats.size() == 0) begin
      tmp.idx = (1 << IW) - 1; tmp.data = '0; beats.push_back(tmp);
    end
    // Reference: a column is recoverable if peeling rows with a single unknown term reaches it
    known = pick[M-1:0];
    do begin
      changed = 1'b0;
      for (int r = M; r < K; r++) begin
        if (!pick[r]) continue;
        cnt = 0; u = 0;
        for (int c = 0; c < M; c++)
          if (sh[r][c] >= 0 && !known[c]) begin cnt++; u = c; end
        if (cnt == 1) begin known[u] = 1'b1; changed = 1'b1; end
      end
    end while (changed);
    for (int i = 0; i < beats.size(); i++) begin
      wait_ready();
      sym_valid_i = 1'b1;
      sym_idx_i   = beats[i].idx[IW-1:0];
      sym_data_i  = beats[i].data;
      sym_last_i  = (i == beats.size() - 1);
      if (beats[i].idx >= K) exp_bad = 1'b1;
      @(posedge clk_i); #1;
      sym_valid_i = 1'b0;
      sym_last_i  = 1'b0;
    end
    if (expect_out) begin
      for (int c = 0; c < M; c++) e.data[c] = known[c] ? d[c] : '0;
      e.ok = &known; e.lost = ~known; e.bad = exp_bad;
      sbq.push_back(e);
      n = 0;
      while (!dec_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
      n_total++;
      if (!dec_valid_o || n > M + 1) begin
        n_bad++;
        $display("FAIL solve_latency cycles=%0d limit=%0d", n, M + 1);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sym_ready"}, 64'(sym_ready_o), 64'(1));
    check({tag, "_dec_valid"}, 64'(dec_valid_o), 64'(0));
    check({tag, "_dec_ok"},    64'(dec_ok_o),    64'(0));
    check({tag, "_dec_lost"},  64'(dec_lost_o),  64'(0));
    check({tag, "_dec_data"},  64'(dec_data_o),  64'(0));
    check({tag, "_bad_idx"},   64'(bad_idx_o),   64'(0));
  endtask

  // Output throttling
  initial begin
    dec_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      dec_ready_i = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: stability while stalled, then scoreboard compare on handshake
  logic [M-1:0][L-2:0] held_dat;
  logic                held_ok;
  logic [M-1:0]        held_lost;
  bit                  held_vld = 1'b0;
  exp_t                got_e;
  always @(negedge clk_i) begin
    if (rst_i) begin
      held_vld = 1'b0;
    end else if (dec_valid_o) begin
      check("ready_low_in_output", 64'(sym_ready_o), 64'(0));
      if (held_vld) begin
        check("stall_data", 64'(dec_data_o), 64'(held_dat));
        check("stall_ok",   64'(dec_ok_o),   64'(held_ok));
        check("stall_lost", 64'(dec_lost_o), 64'(held_lost));
      end
      if (dec_ready_i) begin
        held_vld = 1'b0;
        if (sbq.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL unexpected_output data=0x%0h", dec_data_o);
        end else begin
          got_e = sbq.pop_front();
          check("dec_data", 64'(dec_data_o), 64'(got_e.data));
          check("dec_ok",   64'(dec_ok_o),   64'(got_e.ok));
          check("dec_lost", 64'(dec_lost_o), 64'(got_e.lost));
          check("bad_idx",  64'(bad_idx_o),  64'(got_e.bad));
        end
      end else begin
        held_vld = 1'b1; held_dat = dec_data_o; held_ok = dec_ok_o; held_lost = dec_lost_o;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [M-1:0][L-2:0] d_fix;
  logic [M-1:0][L-2:0] d_rnd;
  initial begin
    rst_i = 1'b1; sym_valid_i = 1'b0; sym_idx_i = '0; sym_data_i = '0; sym_last_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_reset("reset");

    d_fix = {10'h200, 10'h003, 10'h001};
    send_gen(d_fix, 5'b00111, 0, 0, 1);   // all data rows
    send_gen(d_fix, 5'b01101, 0, 0, 1);   // d1 lost, recovered from row3
    send_gen(d_fix, 5'b11010, 0, 0, 1);   // d0 then d2 recovered
    send_gen(d_fix, 5'b01001, 0, 0, 1);   // d2 unrecoverable
    wait_ready();

    // Output held under a long stall
    stall_force = 1'b1;
    send_gen(d_fix, 5'b11010, 0, 0, 1);
    repeat (6) @(posedge clk_i);
    #1 stall_force = 1'b0;
    wait_ready();

    // Reset while solving discards the generation
    send_gen(d_fix, 5'b11010, 0, 0, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_bad = 1'b0;
    check_reset("mid_solve_rst");

    // Lone out-of-range last beat, then a normal generation with the flag still set
    send_gen(d_fix, 5'b00000, 1, 0, 1);
    send_gen(d_fix, 5'b00111, 0, 0, 1);

    for (int g = 0; g < 40; g++) begin
      for (int c = 0; c < M; c++) d_rnd[c] = (L-1)'($urandom);
      send_gen(d_rnd, K'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 2), 1);
    end

    wait_ready();
    repeat (4) @(posedge clk_i);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
